// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths and FSM state encoding for master_out_port
package bus_pkg;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int BLEN_W    = 4;
  localparam int ADDR_BITS = 12;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/bus_serializer.sv
// rtl/bus_serializer.sv - loadable LSB-first parallel-in/serial-out shifter with bit counter
module bus_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             last
);
  logic [WIDTH-1:0] sr;

  // sout is the flop holding the bit on the wire; clr parks the line low
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sr      <= '0;
      sout    <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= din >> 1;
      sout    <= din[0];
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= sr >> 1;
      sout    <= sr[0];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign last = (bit_cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/master_out_port.sv
// rtl/master_out_port.sv - serial bus master port; burst support under MASTER_BURST_EN
module master_out_port #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int BLEN_W = bus_pkg::BLEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BLEN_W-1:0] req_burst_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic              slave_ready,
  output logic              master_valid,
  output logic              read_en,
  output logic              write_en,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  output logic              tx_done
);
  import bus_pkg::*;

  localparam int ACNT_W = $clog2(ADDR_W);
  localparam int DCNT_W = $clog2(DATA_W);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, data_din;
  logic                write_q;
  logic [BLEN_W-1:0]   len_q, beat_q, req_len_eff;
  logic                capture, beat_inc, more_beats;
  logic                addr_load, addr_shift, addr_clr, addr_last;
  logic                data_load, data_shift, data_clr, data_last;
  logic [ACNT_W-1:0]   addr_bit_unused;
  logic [DCNT_W-1:0]   data_cnt;
  logic                busy_d, write_d;
  logic [BLEN_W-1:0]   len_d;
  logic                req_ready_d, master_valid_d, read_en_d, write_en_d;
  logic                tx_burst_d, tx_done_d, wdata_ready_d;

`ifdef MASTER_BURST_EN
  assign req_len_eff = req_burst_len;
`else
  logic burst_len_unused;
  assign burst_len_unused = ^req_burst_len;
  assign req_len_eff      = '0;
`endif

  assign more_beats = (beat_q < len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      req_ready    <= 1'b1;
      master_valid <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      tx_burst     <= 1'b0;
      tx_done      <= 1'b0;
      wdata_ready  <= 1'b0;
    end else begin
      state        <= next_state;
      write_q      <= write_d;
      len_q        <= len_d;
      if (capture) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        beat_q  <= '0;
      end else if (beat_inc) begin
        beat_q  <= beat_q + 1'b1;
      end
      req_ready    <= req_ready_d;
      master_valid <= master_valid_d;
      read_en      <= read_en_d;
      write_en     <= write_en_d;
      tx_burst     <= tx_burst_d;
      tx_done      <= tx_done_d;
      wdata_ready  <= wdata_ready_d;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    beat_inc   = 1'b0;
    addr_load  = 1'b0;
    addr_shift = 1'b0;
    addr_clr   = 1'b0;
    data_load  = 1'b0;
    data_shift = 1'b0;
    data_clr   = 1'b0;
    data_din   = wdata_q;
    unique case (state)
      IDLE: if (req_valid) begin
        capture    = 1'b1;
        next_state = REQ;
      end
      REQ: if (slave_ready) begin
        addr_load  = 1'b1;
        next_state = ADDR;
      end
      ADDR: if (addr_last) begin
        addr_clr = 1'b1;
        if (write_q) begin
          data_load  = 1'b1;
          next_state = DATA;
        end else begin
          next_state = DONE;
        end
      end else begin
        addr_shift = 1'b1;
      end
      DATA: if (!data_last) begin
        data_shift = 1'b1;
      end else if (more_beats) begin
        if (wdata_valid) begin
          data_load = 1'b1;
          data_din  = req_wdata;
          beat_inc  = 1'b1;
        end else begin
          data_clr   = 1'b1;
          next_state = WAIT;
        end
      end else begin
        data_clr   = 1'b1;
        next_state = DONE;
      end
      WAIT: if (wdata_valid) begin
        data_load  = 1'b1;
        data_din   = req_wdata;
        beat_inc   = 1'b1;
        next_state = DATA;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next-cycle state so every port comes straight off a flop
  always_comb begin
    busy_d         = (next_state != IDLE);
    write_d        = capture ? req_write : write_q;
    len_d          = capture ? req_len_eff : len_q;
    req_ready_d    = !busy_d;
    master_valid_d = busy_d;
    read_en_d      = busy_d && !write_d;
    write_en_d     = busy_d && write_d;
    tx_burst_d     = busy_d && (len_d != '0);
    tx_done_d      = (next_state == DONE);
    wdata_ready_d  = (next_state == WAIT) ||
                     (data_shift && (data_cnt == DCNT_W'(DATA_W - 2)) && more_beats);
  end

  bus_serializer #(.WIDTH(ADDR_W)) u_addr_ser (
    .clk     (clk),
    .reset   (reset),
    .clr     (addr_clr),
    .load    (addr_load),
    .shift   (addr_shift),
    .din     (addr_q),
    .sout    (tx_address),
    .bit_cnt (addr_bit_unused),
    .last    (addr_last)
  );

  bus_serializer #(.WIDTH(DATA_W)) u_data_ser (
    .clk     (clk),
    .reset   (reset),
    .clr     (data_clr),
    .load    (data_load),
    .shift   (data_shift),
    .din     (data_din),
    .sout    (tx_data),
    .bit_cnt (data_cnt),
    .last    (data_last)
  );
endmodule

// File: tb/tb_master_out_port.sv
// tb/tb_master_out_port.sv - scoreboard bench for master_out_port (burst cases under MASTER_BURST_EN)
module tb_master_out_port;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_write, wdata_valid, slave_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic [3:0]  req_burst_len;
  logic        req_ready, wdata_ready, master_valid, read_en, write_en;
  logic        tx_address, tx_data, tx_burst, tx_done;

  typedef struct packed {
    logic req_ready, master_valid, read_en, write_en;
    logic tx_address, tx_data, tx_burst, tx_done, wdata_ready;
  } obs_t;

  typedef struct {
    int   cyc;
    int   id;
    obs_t v;
  } exp_t;

  localparam obs_t IDLE_V = 9'b1_0000_0000;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  master_out_port dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_burst_len (req_burst_len),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .slave_ready   (slave_ready),
    .master_valid  (master_valid),
    .read_en       (read_en),
    .write_en      (write_en),
    .tx_address    (tx_address),
    .tx_data       (tx_data),
    .tx_burst      (tx_burst),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input int id, input obs_t v);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    e.v   = v;
    return e;
  endfunction

  function automatic obs_t busy_v(input logic w, input logic tb, input logic ta,
                                  input logic td, input logic dn, input logic rdy);
    obs_t o;
    o.req_ready    = 1'b0;
    o.master_valid = 1'b1;
    o.read_en      = !w;
    o.write_en     = w;
    o.tx_address   = ta;
    o.tx_data      = td;
    o.tx_burst     = tb;
    o.tx_done      = dn;
    o.wdata_ready  = rdy;
    return o;
  endfunction

  // Monitor: compares the head entry when its cycle comes up; overdue entries count as misses
  always @(negedge clk) begin
    obs_t act;
    exp_t e;
    act = {req_ready, master_valid, read_en, write_en, tx_address, tx_data,
           tx_burst, tx_done, wdata_ready};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      vectors++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL txn%0d cyc=%0d outputs got=%b want=%b (rr mv rd wr ta td tb dn wrdy)",
                 e.id, cyc, act, e.v);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      vectors++;
      errors++;
      $display("FAIL txn%0d cyc=%0d vector never sampled got=%b want=%b", e.id, e.cyc, act, e.v);
    end
  end

  task automatic run_txn(input int id, input logic wr_op, input logic [11:0] addr,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int blen, input int sr_delay, input int wait_n,
                         input int pulse_k, input int rst_k);
    exp_t       lq[$];
    logic       rv [256];
    logic       wv [256];
    logic       sr [256];
    logic [7:0] wd [256];
    logic [7:0] bts [16];
    int         t0, a, r, n, len, rc;
    logic       tb;
    t0 = cyc;
`ifdef MASTER_BURST_EN
    len = blen;
`else
    len = 0;
`endif
    tb = (len != 0);
    for (int k = 0; k < 256; k++) begin
      rv[k] = 1'b0; wv[k] = 1'b0; sr[k] = 1'b0; wd[k] = 8'h00;
    end
    for (int b = 0; b < 16; b++) bts[b] = 8'(b * 19 + 7);
    bts[0] = b0; bts[1] = b1; bts[2] = b2;
    rv[0] = 1'b1;
    wd[0] = b0;

    lq.push_back(mk(0, id, IDLE_V));
    for (int k = 1; k <= sr_delay + 1; k++) lq.push_back(mk(k, id, busy_v(wr_op, tb, 0, 0, 0, 0)));
    sr[sr_delay + 1] = 1'b1;
    a = sr_delay + 2;
    for (int i = 0; i < 12; i++) lq.push_back(mk(a + i, id, busy_v(wr_op, tb, addr[i], 0, 0, 0)));
    r = a + 12;
    if (wr_op) begin
      for (int b = 0; b <= len; b++) begin
        for (int i = 0; i < 8; i++)
          lq.push_back(mk(r + i, id, busy_v(wr_op, tb, 0, bts[b][i], 0, (i == 7) && (b < len))));
        r += 8;
        if (b < len) begin
          if (b == 0 && wait_n > 0) begin
            for (int j = 0; j < wait_n; j++) lq.push_back(mk(r + j, id, busy_v(wr_op, tb, 0, 0, 0, 1)));
            r += wait_n;
          end
          wv[r - 1] = 1'b1;
          wd[r - 1] = bts[b + 1];
        end
      end
    end
    lq.push_back(mk(r, id, busy_v(wr_op, tb, 0, 0, 1, 0)));
    lq.push_back(mk(r + 1, id, IDLE_V));
    n = r + 1;
    if (pulse_k >= 0) begin
      rv[a + 12 + pulse_k] = 1'b1;
      wd[a + 12 + pulse_k] = 8'hEE;
    end

    rc = (rst_k >= 0) ? a + rst_k : -1;
    foreach (lq[i]) if (rc < 0 || lq[i].cyc <= rc) sb.push_back(mk(t0 + lq[i].cyc, id, lq[i].v));
    if (rc >= 0) begin
      for (int k = rc + 1; k <= rc + 3; k++) sb.push_back(mk(t0 + k, id, IDLE_V));
      n = rc + 3;
    end

    for (int k = 0; k <= n; k++) begin
      reset         = (k == rc);
      req_valid     = rv[k];
      req_write     = (k == 0) ? wr_op : !wr_op;
      req_addr      = (k == 0) ? addr : 12'hFFF;
      req_burst_len = (k == 0) ? 4'(blen) : 4'hF;
      req_wdata     = wd[k];
      wdata_valid   = wv[k];
      slave_ready   = sr[k];
      @(posedge clk); #1;
    end
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_burst_len = '0; req_wdata = '0; wdata_valid = 1'b0; slave_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_burst_len = '0; wdata_valid = 1'b0; slave_ready = 1'b0;
    @(posedge clk); #1;
    sb.push_back(mk(cyc, 0, IDLE_V));
    @(posedge clk); #1;
    reset = 1'b0;
    sb.push_back(mk(cyc, 0, IDLE_V));
    @(posedge clk); #1;

    run_txn(1, 1'b1, 12'h3C1, 8'hA5, 8'h00, 8'h00, 0, 0, 0, -1, -1);
    run_txn(2, 1'b0, 12'h0FF, 8'h00, 8'h00, 8'h00, 0, 5, 0, -1, -1);
    run_txn(3, 1'b1, 12'h800, 8'h5A, 8'h00, 8'h00, 0, 2, 0, 3, -1);
    run_txn(4, 1'b1, 12'h123, 8'hC3, 8'h00, 8'h00, 0, 0, 0, -1, 6);
    run_txn(5, 1'b1, 12'h001, 8'h81, 8'h00, 8'h00, 0, 1, 0, -1, -1);
    run_txn(6, 1'b1, 12'h2AA, 8'h11, 8'h22, 8'h33, 2, 0, 0, -1, -1);
    run_txn(7, 1'b1, 12'h555, 8'h0F, 8'hF0, 8'h00, 1, 0, 4, -1, -1);
    run_txn(8, 1'b1, 12'hABC, 8'h01, 8'h02, 8'h04, 15, 0, 0, -1, -1);

    repeat (6) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
